// File: rtl/neuron_layer_driver.sv
// Layer sequencer: time-multiplexes one 4-input MAC neuron across
// NUM_NEURONS weight rows, requantizes each result (ReLU, shift, saturate)
// and assembles the 5-bit activation vector for the next layer.
module neuron_layer_driver #(
  parameter int NUM_NEURONS = 4,
  parameter int SHIFT       = 3,
  parameter int TIMEOUT     = 8,
  localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [19:0]              in_vec,
  input  logic                     w_wr_en,
  input  logic [AW-1:0]            w_wr_addr,
  input  logic [19:0]              w_wr_data,
  output logic                     n_input_ready,
  output logic [4:0]               n_in0,
  output logic [4:0]               n_in1,
  output logic [4:0]               n_in2,
  output logic [4:0]               n_in3,
  output logic [4:0]               n_w0,
  output logic [4:0]               n_w1,
  output logic [4:0]               n_w2,
  output logic [4:0]               n_w3,
  input  logic                     n_result_ready,
  input  logic [11:0]              n_result,
  output logic                     out_valid,
  output logic [AW-1:0]            out_idx,
  output logic [4:0]               out_act,
  output logic [5*NUM_NEURONS-1:0] out_vec,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                             state_q, state_d;
  logic [NUM_NEURONS-1:0][19:0]       wts_q;
  logic [NUM_NEURONS-1:0][4:0]        ov_q;
  logic [19:0]                        in_q;
  logic [AW-1:0]                      row_q;
  logic [CW-1:0]                      cnt_q;
  logic                               accept, wr_ok, res_take, tmo, last_row;
  logic [4:0]                         act;
  logic [19:0]                        cur_w;

  // ReLU, scale down, clamp to the non-negative 4-bit range of the next layer
  function automatic logic [4:0] requant(input logic signed [11:0] r);
    logic signed [11:0] t;
    t = r >>> SHIFT;
    if (r[11])          return 5'd0;
    if (t > 12'sd15)    return 5'd15;
    return {1'b0, t[3:0]};
  endfunction

  assign act      = requant(n_result);
  assign last_row = (row_q == AW'(NUM_NEURONS - 1));
  assign cur_w    = wts_q[row_q];

  // Neuron request bus is only live during the single ISSUE cycle
  assign n_input_ready = (state_q == S_ISSUE);
  assign n_in0 = n_input_ready ? in_q[4:0]    : 5'd0;
  assign n_in1 = n_input_ready ? in_q[9:5]    : 5'd0;
  assign n_in2 = n_input_ready ? in_q[14:10]  : 5'd0;
  assign n_in3 = n_input_ready ? in_q[19:15]  : 5'd0;
  assign n_w0  = n_input_ready ? cur_w[4:0]   : 5'd0;
  assign n_w1  = n_input_ready ? cur_w[9:5]   : 5'd0;
  assign n_w2  = n_input_ready ? cur_w[14:10] : 5'd0;
  assign n_w3  = n_input_ready ? cur_w[19:15] : 5'd0;

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign out_vec = ov_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    wr_ok    = 1'b0;
    res_take = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      S_IDLE: begin
        wr_ok = w_wr_en && (int'(w_wr_addr) < NUM_NEURONS);
        if (start) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (n_result_ready) begin
          res_take = 1'b1;
          state_d  = last_row ? S_DONE : S_ISSUE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          tmo     = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Weight store, captured inputs, row/timeout counters and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wts_q     <= '0;
      in_q      <= '0;
      ov_q      <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_act   <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // a write in the same cycle as start lands before ISSUE reads it
      if (wr_ok) wts_q[w_wr_addr] <= w_wr_data;
      if (accept) begin
        in_q  <= in_vec;
        row_q <= '0;
        err   <= 1'b0;
      end
      if (state_q == S_ISSUE) cnt_q <= '0;
      if (state_q == S_WAIT && !n_result_ready && !tmo) cnt_q <= cnt_q + 1'b1;
      if (res_take) begin
        ov_q[row_q] <= act;
        out_valid   <= 1'b1;
        out_idx     <= row_q;
        out_act     <= act;
        if (!last_row) row_q <= row_q + 1'b1;
      end
      if (tmo) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_neuron_layer_driver.sv
// Directed bench for neuron_layer_driver with a behavioural neuron stub
// (programmable latency, or never responding) and a result scoreboard.
module tb_neuron_layer_driver;
  localparam int N  = 4;
  localparam int AW = $clog2(N);
  localparam int SH = 3;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, w_wr_en = 1'b0;
  logic [19:0] in_vec = '0, w_wr_data = '0;
  logic [AW-1:0] w_wr_addr = '0;
  logic n_input_ready;
  logic [4:0] n_in0, n_in1, n_in2, n_in3, n_w0, n_w1, n_w2, n_w3;
  logic n_result_ready = 1'b0;
  logic [11:0] n_result = '0;
  logic out_valid, busy, done, err;
  logic [AW-1:0] out_idx;
  logic [4:0] out_act;
  logic [5*N-1:0] out_vec;

  int total = 0, bad = 0;
  int stub_lat = 1;
  bit stub_dead = 1'b0;
  int pend = 0;
  logic [11:0] pval = '0;

  int wt[N][4];
  int ov[N];
  typedef struct { int idx; int act; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  neuron_layer_driver #(.NUM_NEURONS(N), .SHIFT(SH), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .n_input_ready(n_input_ready),
    .n_in0(n_in0), .n_in1(n_in1), .n_in2(n_in2), .n_in3(n_in3),
    .n_w0(n_w0), .n_w1(n_w1), .n_w2(n_w2), .n_w3(n_w3),
    .n_result_ready(n_result_ready), .n_result(n_result),
    .out_valid(out_valid), .out_idx(out_idx), .out_act(out_act), .out_vec(out_vec),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int dot(input logic [4:0] a0, a1, a2, a3, b0, b1, b2, b3);
    return int'($signed(a0)) * int'($signed(b0)) + int'($signed(a1)) * int'($signed(b1)) +
           int'($signed(a2)) * int'($signed(b2)) + int'($signed(a3)) * int'($signed(b3));
  endfunction

  function automatic int qact(input int s);
    int t;
    if (s < 0) return 0;
    t = s >>> SH;
    return (t > 15) ? 15 : t;
  endfunction

  function automatic logic [19:0] pack4(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [5*N-1:0] model_vec();
    logic [5*N-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++) v[5*r +: 5] = 5'(ov[r]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Neuron stub: registered dot product, result_ready stub_lat cycles after request
  always @(posedge clk) begin
    n_result_ready <= 1'b0;
    if (rst) begin
      pend <= 0;
    end else if (n_input_ready && !stub_dead) begin
      if (stub_lat == 1) begin
        n_result_ready <= 1'b1;
        n_result <= 12'(dot(n_in0, n_in1, n_in2, n_in3, n_w0, n_w1, n_w2, n_w3));
      end else begin
        pend <= stub_lat - 1;
        pval <= 12'(dot(n_in0, n_in1, n_in2, n_in3, n_w0, n_w1, n_w2, n_w3));
      end
    end else if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        n_result_ready <= 1'b1;
        n_result <= pval;
      end
    end
  end

  // Scoreboard consumer
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) begin
      if (sbq.size() == 0) chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      else begin
        mon_e = sbq.pop_front();
        chk("out_idx", {{(32-AW){1'b0}}, out_idx}, mon_e.idx);
        chk("out_act", {27'd0, out_act}, mon_e.act);
      end
    end
  end

  task automatic wr_row(input int r, input int a, input int b, input int c, input int d);
    @(negedge clk);
    w_wr_en = 1'b1; w_wr_addr = AW'(r); w_wr_data = pack4(a, b, c, d);
    wt[r][0] = a; wt[r][1] = b; wt[r][2] = c; wt[r][3] = d;
    @(negedge clk);
    w_wr_en = 1'b0;
  endtask

  task automatic push_row(input int r, input int v);
    int s;
    exp_t e;
    s = 0;
    for (int i = 0; i < 4; i++) s += wt[r][i] * v;
    e.idx = r; e.act = qact(s);
    ov[r] = e.act;
    sbq.push_back(e);
  endtask

  // One layer with all four inputs = v; checks done cycle, busy span, err, out_vec
  task automatic run_layer(input string tag, input int v, input int lat, input bit dead,
                           input bit poke, input int exp_done);
    int done_cyc;
    bit busy_ok;
    stub_lat = lat; stub_dead = dead;
    if (!dead) for (int r = 0; r < N; r++) push_row(r, v);
    @(posedge clk); #1;
    start = 1'b1; in_vec = pack4(v, v, v, v);
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = -1; busy_ok = 1'b1;
    for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (poke && k == 3) begin
        start = 1'b1; w_wr_en = 1'b1; w_wr_addr = AW'(1); w_wr_data = '0;
      end
      if (poke && k == 4) begin start = 1'b0; w_wr_en = 1'b0; end
      if (done === 1'b1) begin
        done_cyc = k;
        chk({tag, "_err"}, {31'd0, err}, {31'd0, dead});
      end
    end
    start = 1'b0; w_wr_en = 1'b0;
    chk({tag, "_done_cycle"}, done_cyc, exp_done);
    chk({tag, "_busy_span"}, {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
    chk({tag, "_out_vec"}, {{(32-5*N){1'b0}}, out_vec}, {{(32-5*N){1'b0}}, model_vec()});
    chk({tag, "_sb_drained"}, sbq.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < N; r++) begin
      ov[r] = 0;
      for (int i = 0; i < 4; i++) wt[r][i] = 0;
    end
    // reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_vec", {{(32-5*N){1'b0}}, out_vec}, 32'd0);
    chk("rst_n_input_ready", {31'd0, n_input_ready}, 32'd0);
    rst = 1'b0;

    // basic layer: acts 3,0,15,0
    wr_row(0, 2, 2, 2, 2);
    wr_row(1, -2, -2, -2, -2);
    wr_row(2, 15, 15, 15, 15);
    wr_row(3, 1, -1, 1, -1);
    run_layer("L_basic", 3, 1, 1'b0, 1'b0, 9);

    // saturation: -16 * -16 * 4 = 1024 -> 15
    wr_row(0, -16, -16, -16, -16);
    wr_row(1, 7, 0, 0, 0);
    wr_row(2, 8, 0, 0, 0);
    wr_row(3, 15, 15, 15, 15);
    run_layer("L_sat", -16, 1, 1'b0, 1'b0, 9);

    // sums -64, 7, 8, 60 with a 3-cycle neuron
    run_layer("L_lat3", 1, 3, 1'b0, 1'b0, 17);

    // neuron never answers: err after 8 WAIT cycles, out_vec untouched
    run_layer("L_timeout", 1, 1, 1'b1, 1'b0, 10);

    // clears err; start/weight write attempted while busy must be ignored
    run_layer("L_poke", 3, 1, 1'b0, 1'b1, 9);
    run_layer("L_rows_kept", 1, 1, 1'b0, 1'b0, 9);

    // reset during WAIT of row 2
    stub_lat = 1; stub_dead = 1'b0;
    push_row(0, 3);
    push_row(1, 3);
    @(posedge clk); #1;
    start = 1'b1; in_vec = pack4(3, 3, 3, 3);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_wait_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_act", {27'd0, out_act}, 32'd0);
    chk("mid_rst_out_vec", {{(32-5*N){1'b0}}, out_vec}, 32'd0);
    chk("mid_rst_sb_drained", sbq.size(), 32'd0);
    for (int r = 0; r < N; r++) begin
      ov[r] = 0;
      for (int i = 0; i < 4; i++) wt[r][i] = 0;
    end
    @(negedge clk);
    chk("mid_rst_no_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    wr_row(0, 2, 2, 2, 2);
    wr_row(1, -2, -2, -2, -2);
    wr_row(2, 15, 15, 15, 15);
    wr_row(3, 1, -1, 1, -1);
    run_layer("L_after_rst", 3, 1, 1'b0, 1'b0, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
